// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding and the size/alignment/legality decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_DONE  = 2'd2
    } lsu_state_t;

    // Access width in bytes; illegal encodings report 1 so range math stays sane.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_H, F3_HU: access_size = 3'd2;
            F3_W:        access_size = 3'd4;
            default:     access_size = 3'd1;
        endcase
    endfunction

    // Half needs even address, word needs 4-byte alignment, bytes always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: is_misaligned = addr_lo[0];
            F3_W:        is_misaligned = (addr_lo != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_legal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load result formatter: picks the byte/half at the given
// offset inside a 32-bit word and sign- or zero-extends it per funct3.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0] lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = data[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte/half, then extend according to the load type.
    always_comb begin
        byte_sel = lane[offset];
        half_sel = offset[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core's execute stage and data_memory.
// Aligned accesses pass straight through in zero cycles; misaligned ones
// (when enabled) are broken into byte cycles while the core is stalled,
// with load bytes gathered into a buffer and formatted in a DONE cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MISALIGN_EN = 1,
    parameter int MEM_BYTES   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        lsu_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    lsu_state_t  state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [31:0] byte_buf_reg, byte_buf_next;

    // Request decode; every error check is resolved in the detect cycle.
    logic [2:0]  size;
    logic [31:0] last_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;

    assign size         = access_size(req_funct3);
    assign last_addr    = req_addr + {29'd0, size} - 32'd1;
    assign misaligned   = is_misaligned(req_funct3, req_addr[1:0]);
    // Checking the first byte as well catches sequences that wrap past 2^32.
    assign out_of_range = (req_addr >= MEM_LIMIT) || (last_addr >= MEM_LIMIT);
    assign req_err      = !is_legal(req_funct3, req_we) || out_of_range
                          || (misaligned && (MISALIGN_EN == 0));

    // Byte-cycle addressing: index 0 is issued from IDLE, the rest from SPLIT.
    logic [1:0]  byte_idx;
    logic [31:0] byte_addr;
    logic [7:0]  rdata_lane [4];
    logic [7:0]  wdata_lane [4];
    logic [7:0]  rd_byte;

    assign byte_idx  = (state_reg == ST_SPLIT) ? idx_reg : 2'd0;
    assign byte_addr = req_addr + {30'd0, byte_idx};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
            assign rdata_lane[gi] = mem_rdata[8*gi +: 8];
            assign wdata_lane[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    assign rd_byte = rdata_lane[byte_addr[1:0]];

    // One extender serves both the aligned pass-through and the buffered result.
    logic [31:0] ext_data;
    logic [1:0]  ext_offset;
    logic [31:0] ext_result;

    assign ext_data   = (state_reg == ST_DONE) ? byte_buf_reg : mem_rdata;
    assign ext_offset = (state_reg == ST_DONE) ? 2'd0 : req_addr[1:0];

    load_extend u_load_extend (
        .data   (ext_data),
        .offset (ext_offset),
        .funct3 (req_funct3),
        .result (ext_result)
    );

    // Next-state, memory strobes and core-facing outputs.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        byte_buf_next = byte_buf_reg;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_funct3    = F3_B;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        stall         = 1'b0;
        lsu_err       = 1'b0;
        load_data     = 32'd0;

        case (state_reg)
            ST_IDLE: begin
                idx_next = 2'd0;
                if (req_valid) begin
                    if (req_err) begin
                        lsu_err = 1'b1;
                    end else if (misaligned) begin
                        stall      = 1'b1;
                        mem_read   = !req_we;
                        mem_write  = req_we;
                        mem_funct3 = F3_B;
                        mem_addr   = byte_addr;
                        mem_wdata  = {24'd0, wdata_lane[byte_idx]};
                        if (!req_we) begin
                            byte_buf_next[{byte_idx, 3'b000} +: 8] = rd_byte;
                        end
                        idx_next   = 2'd1;
                        state_next = ST_SPLIT;
                    end else begin
                        mem_read   = !req_we;
                        mem_write  = req_we;
                        mem_funct3 = req_funct3;
                        mem_addr   = req_addr;
                        mem_wdata  = req_wdata;
                        load_data  = req_we ? 32'd0 : ext_result;
                    end
                end
            end

            ST_SPLIT: begin
                stall      = 1'b1;
                mem_read   = !req_we;
                mem_write  = req_we;
                mem_funct3 = F3_B;
                mem_addr   = byte_addr;
                mem_wdata  = {24'd0, wdata_lane[byte_idx]};
                if (!req_we) begin
                    byte_buf_next[{byte_idx, 3'b000} +: 8] = rd_byte;
                end
                if ({1'b0, idx_reg} == (size - 3'd1)) begin
                    idx_next   = 2'd0;
                    state_next = ST_DONE;
                end else begin
                    idx_next = idx_reg + 2'd1;
                end
            end

            ST_DONE: begin
                load_data  = req_we ? 32'd0 : ext_result;
                idx_next   = 2'd0;
                state_next = ST_IDLE;
            end

            default: begin
                idx_next   = 2'd0;
                state_next = ST_IDLE;
            end
        endcase

        // Reset silences the memory port immediately so an aborted split writes nothing more.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            stall     = 1'b0;
            lsu_err   = 1'b0;
            load_data = 32'd0;
        end
    end

    // State, byte index and gather buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 2'd0;
            byte_buf_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            byte_buf_reg <= byte_buf_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural data memory, one DUT
// with misaligned splitting enabled and one with it disabled.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dut_valid = 1'b0;
    logic        nm_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        init_req = 1'b0;

    logic [31:0] ld_data, maddr, mwdata, mrdata;
    logic        stall, err, mrd, mwr;
    logic [2:0]  mf3;
    logic [31:0] nm_ld_data, nm_maddr, nm_mwdata, nm_mrdata;
    logic        nm_stall, nm_err, nm_mrd, nm_mwr;
    logic [2:0]  nm_mf3;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign mrdata    = mem[maddr[7:2]];
    assign nm_mrdata = mem[nm_maddr[7:2]];

    load_store_unit #(.MISALIGN_EN(1), .MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst), .req_valid(dut_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(ld_data), .stall(stall), .lsu_err(err),
        .mem_read(mrd), .mem_write(mwr), .mem_funct3(mf3),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_rdata(mrdata)
    );

    load_store_unit #(.MISALIGN_EN(0), .MEM_BYTES(256)) dut_nm (
        .clk(clk), .rst(rst), .req_valid(nm_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(nm_ld_data), .stall(nm_stall), .lsu_err(nm_err),
        .mem_read(nm_mrd), .mem_write(nm_mwr), .mem_funct3(nm_mf3),
        .mem_addr(nm_maddr), .mem_wdata(nm_mwdata), .mem_rdata(nm_mrdata)
    );

    // Behavioural data_memory: byte/half/word writes at posedge, preload on request.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[0] <= 32'h8899AABB;
            mem[1] <= 32'h11223344;
        end else if (mwr) begin
            case (mf3)
                3'b000:  mem[maddr[7:2]][{maddr[1:0], 3'b000} +: 8]  <= mwdata[7:0];
                3'b001:  mem[maddr[7:2]][{maddr[1], 4'b0000} +: 16] <= mwdata[15:0];
                default: mem[maddr[7:2]] <= mwdata;
            endcase
        end
    end

    typedef struct {
        string       tag;
        bit          chk_data;
        logic [31:0] data;
        int          stalls;
        logic        err;
        int          strobes;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic init_mem();
        @(posedge clk); #1 init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
    endtask

    // Drive one request, push its expectation, follow it to the first
    // non-stalled cycle, then pop and compare.
    task automatic run_txn(input string tag, input bit use_nm, input logic we,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit chk_data,
                           input logic [31:0] exp_data, input int exp_stalls,
                           input logic exp_err, input int exp_strobes);
        exp_t        e;
        int          stall_cnt;
        int          strobe_cnt;
        bit          done;
        logic [31:0] o_data;
        logic        o_err;
        e.tag = tag; e.chk_data = chk_data; e.data = exp_data;
        e.stalls = exp_stalls; e.err = exp_err; e.strobes = exp_strobes;
        exp_q.push_back(e);

        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        dut_valid = !use_nm; nm_valid = use_nm;
        stall_cnt = 0; strobe_cnt = 0; done = 1'b0; o_data = 32'd0; o_err = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (use_nm ? (nm_mrd | nm_mwr) : (mrd | mwr)) begin
                check_eq({tag, "_addr"}, use_nm ? nm_maddr : maddr, addr + 32'(strobe_cnt));
                strobe_cnt++;
            end
            if (use_nm ? nm_stall : stall) begin
                stall_cnt++;
            end else begin
                done   = 1'b1;
                o_data = use_nm ? nm_ld_data : ld_data;
                o_err  = use_nm ? nm_err : err;
            end
        end
        if (!done) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        dut_valid = 1'b0; nm_valid = 1'b0; req_we = 1'b0;

        e = exp_q.pop_front();
        if (e.chk_data) check_eq({e.tag, "_data"}, o_data, e.data);
        check_eq({e.tag, "_stall"}, 32'(stall_cnt), 32'(e.stalls));
        check_eq({e.tag, "_err"}, {31'd0, o_err}, {31'd0, e.err});
        check_eq({e.tag, "_strobes"}, 32'(strobe_cnt), 32'(e.strobes));
        $display("txn %-10s we=%0d f3=%0d addr=%h load_data=%h stall_cycles=%0d err=%0d strobes=%0d",
                 e.tag, we, f3, addr, o_data, stall_cnt, o_err, strobe_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour: strobes held low even with a store pending.
        rst = 1'b1;
        init_mem();
        @(posedge clk); #1;
        dut_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'd0; req_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        check_eq("rst_outs", {28'd0, mrd, mwr, stall, err}, 32'd0);
        check_eq("rst_ldata", ld_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dut_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        check_eq("idle_outs", {28'd0, mrd, mwr, stall, err}, 32'd0);
        check_eq("idle_ldata", ld_data, 32'd0);
        check_eq("rst_nowrite", mem[0], 32'h8899AABB);

        // Aligned loads, then split loads.
        run_txn("lw0",   0, 0, F3_W,  32'd0, 32'd0, 1, 32'h8899AABB, 0, 0, 1);
        run_txn("lb1",   0, 0, F3_B,  32'd1, 32'd0, 1, 32'hFFFFFFAA, 0, 0, 1);
        run_txn("lbu1",  0, 0, F3_BU, 32'd1, 32'd0, 1, 32'h000000AA, 0, 0, 1);
        run_txn("lh2",   0, 0, F3_H,  32'd2, 32'd0, 1, 32'hFFFF8899, 0, 0, 1);
        run_txn("lhu2",  0, 0, F3_HU, 32'd2, 32'd0, 1, 32'h00008899, 0, 0, 1);
        run_txn("lw3",   0, 0, F3_W,  32'd3, 32'd0, 1, 32'h22334488, 4, 0, 4);
        run_txn("lh3",   0, 0, F3_H,  32'd3, 32'd0, 1, 32'h00004488, 2, 0, 2);
        run_txn("lh1",   0, 0, F3_H,  32'd1, 32'd0, 1, 32'hFFFF99AA, 2, 0, 2);
        run_txn("lhu1",  0, 0, F3_HU, 32'd1, 32'd0, 1, 32'h000099AA, 2, 0, 2);

        // Split store and aligned half store.
        run_txn("sw1",   0, 1, F3_W,  32'd1, 32'hDEADBEEF, 0, 32'd0, 4, 0, 4);
        check_eq("sw1_word0", mem[0], 32'hADBEEFBB);
        check_eq("sw1_word1", mem[1], 32'h112233DE);
        run_txn("sh6",   0, 1, F3_H,  32'd6, 32'h1234CAFE, 0, 32'd0, 0, 0, 1);
        check_eq("sh6_word1", mem[1], 32'hCAFE33DE);
        run_txn("lw4",   0, 0, F3_W,  32'd4, 32'd0, 1, 32'hCAFE33DE, 0, 0, 1);

        // Range and legality boundaries.
        run_txn("lw253", 0, 0, F3_W,  32'd253, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("lw252", 0, 0, F3_W,  32'd252, 32'd0, 1, 32'd0, 0, 0, 1);
        run_txn("lb255", 0, 0, F3_B,  32'd255, 32'd0, 1, 32'd0, 0, 0, 1);
        run_txn("lh255", 0, 0, F3_H,  32'd255, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("sw254", 0, 1, F3_W,  32'd254, 32'h0, 0, 32'd0, 0, 1, 0);
        run_txn("lbwrap",0, 0, F3_B,  32'hFFFFFFFF, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("f3_011",0, 0, 3'b011, 32'd0, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("f3_110",0, 0, 3'b110, 32'd0, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("sbu",   0, 1, F3_BU, 32'd0, 32'h55, 0, 32'd0, 0, 1, 0);
        check_eq("sbu_nowrite", mem[0], 32'hADBEEFBB);

        // Splitting disabled.
        init_mem();
        run_txn("nm_lh1", 1, 0, F3_H, 32'd1, 32'd0, 0, 32'd0, 0, 1, 0);
        run_txn("nm_lw0", 1, 0, F3_W, 32'd0, 32'd0, 1, 32'h8899AABB, 0, 0, 1);
        run_txn("nm_sw2", 1, 1, F3_W, 32'd2, 32'hFFFFFFFF, 0, 32'd0, 0, 1, 0);

        // Reset during the second SPLIT cycle of SW addr 1.
        init_mem();
        @(posedge clk); #1;
        dut_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'd1; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check_eq("abort_c0", {28'd0, mrd, mwr, stall, err}, 32'b0110);
        check_eq("abort_c0_addr", maddr, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("abort_c1", {28'd0, mrd, mwr, stall, err}, 32'b0110);
        check_eq("abort_c1_addr", maddr, 32'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("abort_c2", {28'd0, mrd, mwr, stall, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dut_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        check_eq("abort_after", {28'd0, mrd, mwr, stall, err}, 32'd0);
        check_eq("abort_state", 32'(dut.state_reg), 32'(ST_IDLE));
        check_eq("abort_word0", mem[0], 32'h88BEEFBB);
        check_eq("abort_word1", mem[1], 32'h11223344);
        run_txn("lb1_post", 0, 0, F3_B, 32'd1, 32'd0, 1, 32'hFFFFFFEF, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
